md_unit_ctrl: RTL and testbench
===============================

Name: md_unit_ctrl

Overview:
Multi-cycle multiply/divide controller for the P-series MIPS datapath. It owns the HI/LO register pair and sequences MULT/MULTU/DIV/DIVU over a fixed latency. It raises busy so the hazard unit can stall any later md-class instruction. It sits beside the ALU in the EX stage, takes operands from the EX forwarding muxes, and serves MFHI/MFLO/MTHI/MTLO.

Parameters:
MULT_CYCLES, 5, busy length for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy length for DIV/DIVU (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle request to launch the operation given on op
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  32  rs operand (multiplicand / dividend)
b  input  32  rt operand (multiplier / divisor)
we_hi  input  1  MTHI write strobe
we_lo  input  1  MTLO write strobe
wdata  input  32  MTHI/MTLO data
busy  output  1  operation in flight
done  output  1  one-cycle pulse on the cycle HI/LO take the result
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0. This applies mid-operation too. The in-flight result is discarded and never written.
- States: IDLE, RUN. Counter width is 4 bits.
- IDLE with start=1: at the clock edge, latch a, b and op. Load counter with MULT_CYCLES or DIV_CYCLES according to op. Go to RUN.
- RUN: busy=1 (registered). busy is high for exactly N cycles, starting the cycle after the start edge. The counter decrements each edge.
- On the edge where counter==1: write hi and lo, done=1 for the following cycle, return to IDLE, busy=0.
- Back-to-back: start is accepted on the first IDLE cycle after busy falls.
- start while RUN: ignored. The hazard unit guarantees this never happens, but the block must not corrupt state.
- we_hi/we_lo in IDLE: the target register takes wdata at the next edge. Both strobes together write both registers.
- we_hi/we_lo while RUN: ignored.
- start together with we_hi/we_lo in IDLE: start wins, the write is dropped.
- hi/lo are registered outputs and change only at a result write, an MT write or reset. During RUN they hold the previous values.
- MULT: signed 32x32 product to 64 bits; hi={p[63:32]}, lo={p[31:0]}.
- MULTU: the same with unsigned operands.
- DIV: signed division; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
- DIV overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000.
- DIVU: unsigned division; lo=quotient, hi=remainder.
- Divisor 0 (DIV or DIVU): runs the full DIV_CYCLES with busy and done as normal. hi and lo are left unchanged.
- Results are computed from the latched operands only. Changes on a/b during RUN have no effect.
- done is high for exactly one cycle per completed operation, including the divide-by-zero case.

Test Plan:
- Reset sequence: reset=1 mid-RUN of a DIV -> busy=0, done=0, hi=lo=0 immediately (async); no later write occurs after reset releases.
- MULT a=0xFFFFFFFF b=0x00000002, start 1 cycle -> busy high exactly 5 cycles; on the final edge hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7 b=0 -> busy 10 cycles, done pulses, hi/lo unchanged.
- MTHI wdata=0x12345678 in IDLE -> hi=0x12345678 next edge. MTLO with wdata=0xAAAA5555 during RUN -> lo unchanged. start+we_lo in the same IDLE cycle -> only the multiply result is written.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Then a second start issued on the first cycle after busy falls -> accepted. Also assert start during RUN -> no effect on counter or results.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide controller: latches operands on start, holds busy for a fixed
// per-op latency, then writes HI/LO from the latched operands and pulses done.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic        load, finish;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
      end
      RUN: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One 64-bit multiplier serves both MULT and MULTU: operand extension picks signedness.
  logic        is_signed;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [31:0] res_hi, res_lo;
  logic        write_res, mt_ok;

  always_comb begin
    is_signed = ~op_q[0];
    a_ext     = {{32{is_signed & a_q[31]}}, a_q};
    b_ext     = {{32{is_signed & b_q[31]}}, b_q};
    prod      = a_ext * b_ext;

    // Sign-magnitude division; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    a_neg    = is_signed & a_q[31];
    b_neg    = is_signed & b_q[31];
    a_mag    = a_neg ? (32'd0 - a_q) : a_q;
    b_mag    = b_neg ? (32'd0 - b_q) : b_q;
    div_zero = (b_q == 32'd0);
    q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
    r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
    quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem      = a_neg ? (32'd0 - r_mag) : r_mag;

    res_hi    = op_q[1] ? rem  : prod[63:32];
    res_lo    = op_q[1] ? quot : prod[31:0];
    write_res = finish & ~(op_q[1] & div_zero);
    mt_ok     = (state == IDLE) & ~start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      op_q <= 2'd0;
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else begin
      if (load) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      busy <= (state_nxt == RUN);
      done <= finish;
      if (write_res) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        if (mt_ok && we_hi) hi <= wdata;
        if (mt_ok && we_lo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: expected HI/LO pushed per op, monitor pops on done.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        we_hi, we_lo;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int dones_seen = 0;
  int dones_exp = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: each done pulse consumes one expected {hi,lo}.
  always @(negedge clk) begin
    if (!reset && done) begin
      dones_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hi", hi, e[63:32]);
        check("result_lo", lo, e[31:0]);
      end
    end
  end

  // Launch one op (called just after a negedge), optionally disturbing it mid-RUN.
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                       input int n, input bit disturb, input bit mt_with_start);
    int cnt;
    exp_q.push_back({eh, el});
    dones_exp++;
    start = 1'b1; op = o; a = x; b = y;
    if (mt_with_start) begin we_lo = 1'b1; wdata = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
    start = 1'b0; we_lo = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (disturb && cnt == 2) begin
        start = 1'b1; op = 2'b10; a = 32'h0; b = 32'h1;
        we_lo = 1'b1; we_hi = 1'b1; wdata = 32'hAAAA_5555;
      end
      if (disturb && cnt == 3) begin
        start = 1'b0; we_lo = 1'b0; we_hi = 1'b0;
        check({name, "_hold_hi"}, hi, m_hi);
        check({name, "_hold_lo"}, lo, m_lo);
      end
    end
    check({name, "_busy_cycles"}, 32'(cnt), 32'(n));
    m_hi = eh; m_lo = el;
  endtask

  task automatic mt(input string name, input bit wh, input bit wl, input logic [31:0] d);
    we_hi = wh; we_lo = wl; wdata = d;
    @(posedge clk); #1;
    we_hi = 1'b0; we_lo = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    @(negedge clk);
    check({name, "_hi"}, hi, m_hi);
    check({name, "_lo"}, lo, m_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    mt("mthi", 1'b1, 1'b0, 32'h1234_5678);
    mt("mt_both", 1'b1, 1'b1, 32'h0F0F_0F0F);

    do_op("mult", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 1'b1, 1'b0);
    do_op("multu", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0, 1'b0);
    do_op("multu_mt", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b0, 1'b1);
    do_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1, 1'b0);
    do_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0, 1'b0);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10, 1'b0, 1'b0);
    do_op("b2b_divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0, 1'b0);
    do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15, 5, 1'b0, 1'b0);

    // Reset in the middle of a DIV: everything clears at once, no late write.
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_hi", hi, 32'd0);
    check("midrun_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);

    check("done_count", 32'(dones_seen), 32'(dones_exp));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
